// File: rtl/sram_bank_arb_pkg.sv
// Shared types and defaults for the two-port SRAM bank arbiter.
package sram_bank_arb_pkg;

   localparam int AW_DEF = 13;
   localparam int DW_DEF = 32;

   // INIT zero-fills the bank, RUN serves the two ports.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } arb_state_t;

   // Identifies one of the two request ports.
   typedef logic port_idx_t;

   localparam port_idx_t PORT0 = 1'b0;
   localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-granted port.
module rr_arb2
   import sram_bank_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output port_idx_t  last
);

   // Lone requester always wins; on contention the port not granted last wins.
   always_comb begin
      gnt = 2'b00;
      if (advance) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Track the most recent winner; reset favours port 0 on the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= PORT1;
      else if (|gnt)
         last <= gnt[1] ? PORT1 : PORT0;
   end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Two-port arbiter in front of a single-port SRAM bank, with optional
// zero-fill of the whole bank after reset.
module sram_bank_arbiter
   import sram_bank_arb_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int INIT_ZERO = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p0_req_i,
   input  logic            p0_we_i,
   input  logic [AW-1:0]   p0_addr_i,
   input  logic [DW-1:0]   p0_wdata_i,
   input  logic [DW/8-1:0] p0_be_i,
   output logic            p0_gnt_o,
   output logic            p0_rvalid_o,
   output logic [DW-1:0]   p0_rdata_o,
   input  logic            p1_req_i,
   input  logic            p1_we_i,
   input  logic [AW-1:0]   p1_addr_i,
   input  logic [DW-1:0]   p1_wdata_i,
   input  logic [DW/8-1:0] p1_be_i,
   output logic            p1_gnt_o,
   output logic            p1_rvalid_o,
   output logic [DW-1:0]   p1_rdata_o,
   output logic            mem_en_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_be_o,
   input  logic [DW-1:0]   mem_rdata_i,
   output logic            init_busy_o
);

   localparam logic [AW-1:0] LAST_ADDR = '1;

   arb_state_t state;
   logic [AW-1:0] init_cnt;
   logic [1:0]    gnt;
   logic [1:0]    rsp_vld;
   logic [1:0]    rsp_rd;
   logic          init_en;
   logic          run_en;
   port_idx_t     unused_last;

   // Outputs are forced quiet while rst is held, independent of state.
   assign init_en = (state == INIT) && !rst;
   assign run_en  = (state == RUN)  && !rst;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({p1_req_i, p0_req_i}),
      .advance (run_en),
      .gnt     (gnt),
      .last    (unused_last)
   );

   // Zero-fill sweep: writes every address once, stops at the top without wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= (INIT_ZERO != 0) ? INIT : RUN;
         init_cnt <= '0;
      end else if (state == INIT) begin
         if (init_cnt == LAST_ADDR)
            state <= RUN;
         else
            init_cnt <= init_cnt + 1'b1;
      end
   end

   // Bank command mux: fill writes in INIT, granted port in RUN.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (init_en) begin
         mem_en_o   = 1'b1;
         mem_we_o   = 1'b1;
         mem_addr_o = init_cnt;
         mem_be_o   = '1;
      end else if (gnt[0]) begin
         mem_en_o    = 1'b1;
         mem_we_o    = p0_we_i;
         mem_addr_o  = p0_addr_i;
         mem_wdata_o = p0_wdata_i;
         mem_be_o    = p0_be_i;
      end else if (gnt[1]) begin
         mem_en_o    = 1'b1;
         mem_we_o    = p1_we_i;
         mem_addr_o  = p1_addr_i;
         mem_wdata_o = p1_wdata_i;
         mem_be_o    = p1_be_i;
      end
   end

   // One-stage response pipe per port; rsp_rd marks responses that carry data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld <= '0;
         rsp_rd  <= '0;
      end else begin
         rsp_vld <= gnt;
         rsp_rd  <= gnt & {~p1_we_i, ~p0_we_i};
      end
   end

   assign p0_gnt_o    = gnt[0];
   assign p1_gnt_o    = gnt[1];
   assign p0_rvalid_o = rsp_vld[0];
   assign p1_rvalid_o = rsp_vld[1];
   assign p0_rdata_o  = (rsp_vld[0] && rsp_rd[0]) ? mem_rdata_i : '0;
   assign p1_rdata_o  = (rsp_vld[1] && rsp_rd[1]) ? mem_rdata_i : '0;
   assign init_busy_o = (state == INIT);

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: behavioural bank, rule-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sram_bank_arbiter;

   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
   logic [AW-1:0] p0_addr_i, p1_addr_i;
   logic [DW-1:0] p0_wdata_i, p1_wdata_i;
   logic [3:0]    p0_be_i, p1_be_i;
   logic          p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
   logic [DW-1:0] p0_rdata_o, p1_rdata_o;
   logic          mem_en_o, mem_we_o, init_busy_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o, mem_rdata_i;
   logic [3:0]    mem_be_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_bank_arbiter #(.AW(AW), .DW(DW), .INIT_ZERO(1)) dut (
      .clk(clk), .rst(rst),
      .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
      .p0_wdata_i(p0_wdata_i), .p0_be_i(p0_be_i), .p0_gnt_o(p0_gnt_o),
      .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
      .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
      .p1_wdata_i(p1_wdata_i), .p1_be_i(p1_be_i), .p1_gnt_o(p1_gnt_o),
      .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .init_busy_o(init_busy_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
         if (failures >= 50) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   endtask

   // Behavioural bank: byte-masked writes, one-cycle registered read, starts with garbage.
   logic [DW-1:0] bank [0:DEPTH-1];
   logic [DW-1:0] bank_q = '0;
   assign mem_rdata_i = bank_q;

   initial for (int i = 0; i < DEPTH; i++) bank[i] = $urandom;

   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            bank_q <= bank[mem_addr_o];
         end
      end
   end

   // Rule-level model: what the outputs must be this cycle, then advance.
   logic [DW-1:0] shadow [0:DEPTH-1];
   bit            m_init = 1'b1;
   int            m_cnt  = 0;
   bit            m_last = 1'b1;
   bit   [1:0]    m_vld  = '0;
   bit   [1:0]    m_rd   = '0;
   logic [DW-1:0] m_rdv [2];

   initial for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

   always @(negedge clk) begin
      logic [1:0]    e_gnt, r;
      logic          e_en, e_we, e_busy;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rd0, e_rd1;
      logic [3:0]    e_be;
      logic [1:0]    e_rv;
      e_gnt = '0; e_en = 0; e_we = 0; e_busy = 0; e_addr = '0; e_wd = '0; e_be = '0;
      e_rv = '0; e_rd0 = '0; e_rd1 = '0;
      r = {p1_req_i, p0_req_i};
      if (rst) begin
         e_busy = 1;
      end else begin
         e_rv  = m_vld;
         e_rd0 = (m_vld[0] && m_rd[0]) ? m_rdv[0] : '0;
         e_rd1 = (m_vld[1] && m_rd[1]) ? m_rdv[1] : '0;
         if (m_init) begin
            e_busy = 1; e_en = 1; e_we = 1; e_be = 4'hF; e_addr = AW'(m_cnt);
         end else begin
            if (r == 2'b11) e_gnt = m_last ? 2'b01 : 2'b10;
            else            e_gnt = r;
            if (e_gnt[0]) begin
               e_en = 1; e_we = p0_we_i; e_addr = p0_addr_i; e_wd = p0_wdata_i; e_be = p0_be_i;
            end else if (e_gnt[1]) begin
               e_en = 1; e_we = p1_we_i; e_addr = p1_addr_i; e_wd = p1_wdata_i; e_be = p1_be_i;
            end
         end
      end
      chk("cycle_ctl",
          {p0_gnt_o, p1_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
           init_busy_o, p0_rvalid_o, p1_rvalid_o},
          {e_gnt[0], e_gnt[1], e_en, e_we, e_addr, e_wd, e_be, e_busy, e_rv[0], e_rv[1]});
      chk("cycle_p0_rdata", p0_rdata_o, e_rd0);
      chk("cycle_p1_rdata", p1_rdata_o, e_rd1);
      // advance the model by one clock
      if (rst) begin
         m_init = 1; m_cnt = 0; m_last = 1; m_vld = '0; m_rd = '0;
      end else if (m_init) begin
         shadow[m_cnt] = '0;
         m_vld = '0; m_rd = '0;
         if (m_cnt == DEPTH - 1) m_init = 0;
         else                    m_cnt++;
      end else begin
         m_vld = e_gnt;
         m_rd  = e_gnt & {~e_we, ~e_we};
         if (e_gnt != 2'b00) begin
            m_last = e_gnt[1];
            m_rdv[e_gnt[1]] = shadow[e_addr];
            if (e_we)
               for (int b = 0; b < 4; b++)
                  if (e_be[b]) shadow[e_addr][8*b +: 8] = e_wd[8*b +: 8];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, g0, g1, r0, r1;
      logic [3:0] s0, s1, v0, v1;
      rst = 1;
      p0_req_i = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0; p0_be_i = '0;
      p1_req_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0; p1_be_i = '0;
      repeat (3) @(posedge clk);
      #3;
      chk("reset_outputs", {mem_en_o, mem_we_o, p0_gnt_o, p1_gnt_o, init_busy_o}, 5'b00001);
      step();
      rst = 0;

      // full zero-fill length
      n = 0;
      while (init_busy_o && n < 9000) begin step(); n++; end
      chk("init_len", n, 8192);

      // first RUN read of the top address returns the filled zero
      p0_req_i = 1; p0_we_i = 0; p0_addr_i = 13'h1FFF;
      #2 chk("top_read_gnt", p0_gnt_o, 1);
      step(); p0_req_i = 0;
      #2 chk("top_read_data", {p0_rvalid_o, p0_rdata_o}, {1'b1, 32'h0});

      // partial byte-enable write then read back
      step();
      p0_req_i = 1; p0_we_i = 1; p0_addr_i = 13'h0123; p0_wdata_i = 32'hDEADBEEF; p0_be_i = 4'b0011;
      step();
      p0_we_i = 0;
      step();
      p0_req_i = 0;
      #2 chk("be_readback", {p0_rvalid_o, p0_rdata_o}, {1'b1, 32'h0000BEEF});

      // p1 alone for 10 cycles
      step();
      g0 = 0; g1 = 0; r0 = 0; r1 = 0;
      for (int k = 0; k < 10; k++) begin
         p1_req_i = 1; p1_we_i = 0; p1_addr_i = AW'(k);
         #2;
         g1 += int'(p1_gnt_o); r1 += int'(p1_rvalid_o);
         g0 += int'(p0_gnt_o); r0 += int'(p0_rvalid_o);
         step();
      end
      p1_req_i = 0;
      #2;
      r1 += int'(p1_rvalid_o); r0 += int'(p0_rvalid_o);
      chk("p1_alone_gnts", g1, 10);
      chk("p1_alone_rvalids", r1, 10);
      chk("p1_alone_p0_quiet", {g0, r0}, 64'h0);

      // p0 read at T, p1 write at T+1
      step();
      p0_req_i = 1; p0_we_i = 0; p0_addr_i = 13'h0123;
      #2 chk("b2b_p0_gnt", p0_gnt_o, 1);
      step();
      p0_req_i = 0;
      p1_req_i = 1; p1_we_i = 1; p1_addr_i = 13'h0200; p1_wdata_i = 32'h5555AAAA; p1_be_i = 4'hF;
      #2 chk("b2b_t1", {p0_rvalid_o, p0_rdata_o, p1_gnt_o}, {1'b1, 32'h0000BEEF, 1'b1});
      step();
      p1_req_i = 0;
      #2 chk("b2b_t2", {p1_rvalid_o, p1_rdata_o, p0_rvalid_o}, {1'b1, 32'h0, 1'b0});

      // reset again, then interrupt the fill at address 100
      step();
      rst = 1;
      step();
      rst = 0;
      n = 0;
      while (mem_addr_o != 13'd100 && n < 200) begin step(); n++; end
      chk("cnt100_reached", n, 100);
      rst = 1;
      p0_req_i = 1; p0_we_i = 0; p0_addr_i = 13'h0123;
      p1_req_i = 1; p1_we_i = 0; p1_addr_i = 13'h1FFF;
      #2 chk("async_rst_quiet", {mem_en_o, mem_addr_o}, 14'h0);
      step();
      rst = 0;
      #2 chk("fill_restart", {mem_en_o, mem_addr_o}, {1'b1, 13'h0});
      n = 0;
      while (init_busy_o && n < 9000) begin step(); n++; end
      chk("refill_len", n, 8192);

      // both ports held across the INIT-to-RUN edge
      s0 = '0; s1 = '0; v0 = '0; v1 = '0;
      for (int k = 0; k < 4; k++) begin
         #2;
         s0[k] = p0_gnt_o; s1[k] = p1_gnt_o; v0[k] = p0_rvalid_o; v1[k] = p1_rvalid_o;
         step();
      end
      chk("rr_p0_gnts", s0, 4'b0101);
      chk("rr_p1_gnts", s1, 4'b1010);
      chk("rr_p0_rvalid", v0, 4'b1010);
      chk("rr_p1_rvalid", v1, 4'b0100);
      p0_req_i = 0; p1_req_i = 0;
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_bank_arbiter.md
SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, word-address width (8192 words).
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter INIT_ZERO, default 1; when 1, the block zero-fills the bank after reset.
REQ-004 SHALL use one clock, clk (input, 1): all state on its rising edge.
REQ-005 SHALL use rst (input, 1): reset, asynchronous, active-high.
REQ-006 SHALL have pN_req_i, input, 1 (N = 0, 1): access request.
REQ-007 SHALL have pN_we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have pN_addr_i, input, AW: word address.
REQ-009 SHALL have pN_wdata_i, input, DW: write data.
REQ-010 SHALL have pN_be_i, input, DW/8: byte enables.
REQ-011 SHALL have pN_gnt_o, output, 1: request accepted this cycle.
REQ-012 SHALL have pN_rvalid_o, output, 1: response cycle.
REQ-013 SHALL have pN_rdata_o, output, DW: read data.
REQ-014 SHALL drive mem_en_o (1), mem_we_o (1), mem_addr_o (AW), mem_wdata_o (DW) and mem_be_o (DW/8) as outputs to the bank.
REQ-015 SHALL take mem_rdata_i, input, DW: bank read data, valid one cycle after a read enable.
REQ-016 SHALL have init_busy_o, output, 1: zero-fill in progress.

Function
REQ-017 SHALL implement FSM states INIT and RUN; reset enters INIT if INIT_ZERO=1, else RUN.
REQ-018 In INIT, the block SHALL drive mem_en_o=1, mem_we_o=1, mem_be_o=all ones, mem_wdata_o=0 and mem_addr_o=init counter (reset value 0), incrementing by 1 per cycle.
REQ-019 On the cycle the init counter equals 2^AW-1, the FSM SHALL write that address and then move to RUN; the counter SHALL NOT wrap.
REQ-020 In INIT, p0_gnt_o and p1_gnt_o SHALL be 0 and init_busy_o SHALL be 1; in RUN, init_busy_o SHALL be 0.
REQ-021 In RUN, grant SHALL be combinational in the same cycle as the request: exactly one requesting port is granted per cycle, and none if neither requests.
REQ-022 Single requester: that port SHALL be granted every cycle it requests.
REQ-023 Both requesting: the port not granted last SHALL win; the last-granted register (reset value = port 1, so port 0 wins first) SHALL update on every grant.
REQ-024 A continuously requesting port SHALL be granted within 2 cycles.
REQ-025 On a grant, the block SHALL drive mem_en_o=1 and mux mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o from the granted port; otherwise mem_en_o=0 and mem_we_o=0.
REQ-026 pN_rvalid_o SHALL be 1 exactly one cycle after each pN grant, for both reads and writes.
REQ-027 pN_rdata_o SHALL equal mem_rdata_i while pN_rvalid_o=1 after a read, and SHALL be 0 otherwise.
REQ-028 Request inputs SHALL be ignored in INIT; a request held across the INIT-to-RUN edge SHALL be granted in the first RUN cycle.
REQ-029 A response owed from the previous grant SHALL be delivered even if the other port is granted in the same cycle (back-to-back, no bubble).

Reset
REQ-030 Asserting rst SHALL asynchronously clear the init counter to 0, set the last-granted register to port 1, clear the rvalid pipeline and set the state per REQ-017.
REQ-031 While in reset, all outputs SHALL be 0, except init_busy_o, which equals INIT_ZERO.
REQ-032 Reset during INIT SHALL restart the fill from address 0; reset during RUN SHALL drop any pending response.

Structure
REQ-033 Package sram_bank_arb_pkg SHALL hold AW/DW defaults, the state enum {INIT, RUN} and the port-index type.
REQ-034 The 2-way round-robin decision SHALL be a sub-module rr_arb2 (req[1:0], advance, gnt[1:0], last-granted register).

Verification
REQ-035 Reset with INIT_ZERO=1 -> init_busy_o=1 for 8192 cycles, with mem_addr_o sweeping 0..0x1FFF and wdata 0; the first RUN read of 0x1FFF returns 0.
REQ-036 Both ports requesting continuously from the first RUN cycle -> grants p0, p1, p0, p1, and each rvalid follows its grant by 1 cycle.
REQ-037 p0 writes 0xDEADBEEF to 0x0123 with be=4'b0011, then reads 0x0123 -> p0_rdata_o = 0x0000BEEF in the rvalid cycle.
REQ-038 rst asserted when the init counter = 100 -> the counter restarts at 0 and the fill completes after 8192 cycles.
REQ-039 p1 requests alone for 10 cycles -> 10 grants and 10 rvalids, while p0_gnt_o and p0_rvalid_o stay 0.
REQ-040 p0 read granted in cycle T and p1 write granted in T+1 -> p0_rvalid_o at T+1 with correct data, and p1_rvalid_o at T+2 with rdata 0.
